sevenseg_decoder: RTL and testbench



---
 rtl/sevenseg_pkg.sv | 39 +++
 rtl/sevenseg_stable_filter.sv | 44 ++++
 rtl/sevenseg_decoder.sv | 120 ++++++++++++
 tb/tb_sevenseg_decoder.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sevenseg_pkg.sv
// Shared definitions for the 7-segment pattern decoder.
//   SEG_BLANK   : all segments off (active-low, gfe_dcba)
//   SEG_DIGIT   : pattern for each digit 0-9; the segment encoder uses the same table
//   seg_decode  : pattern -> {legal, value}
//   seg_state_t : decoder FSM states
package sevenseg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [6:0] SEG_DIGIT [10] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };

    typedef struct packed {
        logic       legal;
        logic [3:0] value;
    } seg_dec_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        TRACK  = 2'd1,
        COMMIT = 2'd2
    } seg_state_t;

    function automatic seg_dec_t seg_decode(input logic [6:0] pattern);
        seg_dec_t r;
        r.legal = 1'b0;
        r.value = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (pattern == SEG_DIGIT[i]) begin
                r.legal = 1'b1;
                r.value = 4'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/sevenseg_stable_filter.sv
// Stability filter: registers the incoming pattern every edge and counts how
// many consecutive samples were identical, saturating at STABLE_CYCLES.
//   clk, rst_n     : clock, async active-low reset
//   run            : counting allowed; when low the counter is held at 0
//   pattern_in     : raw segment pattern
//   stable_pattern : most recent sample
//   stable         : sample has been identical for STABLE_CYCLES samples
module sevenseg_stable_filter
    import sevenseg_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic [6:0] pattern_in,
    output logic [6:0] stable_pattern,
    output logic       stable
);

    logic [6:0] sample;
    logic [3:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample <= SEG_BLANK;
            cnt    <= 4'd0;
        end else begin
            sample <= pattern_in;
            if (!run) begin
                cnt <= 4'd0;
            end else if (pattern_in != sample) begin
                // any change restarts filtering; the new sample is the first of its run
                cnt <= 4'd1;
            end else if (cnt != 4'(STABLE_CYCLES)) begin
                cnt <= cnt + 4'd1;
            end
        end
    end

    assign stable_pattern = sample;
    assign stable         = (cnt == 4'(STABLE_CYCLES));

endmodule

// File: rtl/sevenseg_decoder.sv
// Decodes a filtered active-low 7-segment pattern back into a digit 0-9,
// strobing once per newly committed digit and keeping a short digit history.
//   clk, rst_n   : clock, async active-low reset
//   ledsegments  : active-low pattern, gfe_dcba in [6:0]
//   enable       : decoder active
//   err_clear    : clears seg_error
//   digit        : last accepted digit
//   digit_valid  : committed pattern is a legal digit
//   digit_strobe : one-cycle pulse on a new digit commit
//   blank        : committed pattern is all-off
//   seg_error    : sticky, an illegal pattern was committed
//   history      : committed digits, newest in [3:0]
//   digit_count  : committed digits, saturating at 255
//
// state  | meaning
// IDLE   | disabled; committed pattern forced blank, counter cleared
// TRACK  | filtering; commit when a stable pattern differs from the committed one
// COMMIT | one cycle after a commit, then back to TRACK
module sevenseg_decoder
    import sevenseg_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int HIST_DEPTH    = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [6:0]              ledsegments,
    input  logic                    enable,
    input  logic                    err_clear,
    output logic [6:0]              digit,
    output logic                    digit_valid,
    output logic                    digit_strobe,
    output logic                    blank,
    output logic                    seg_error,
    output logic [4*HIST_DEPTH-1:0] history,
    output logic [7:0]              digit_count
);

    localparam int HW = 4 * HIST_DEPTH;

    seg_state_t state, state_nxt;
    logic [6:0] committed;
    logic [6:0] stable_pattern;
    logic       stable;
    logic       commit_go;
    logic       illegal_go;
    seg_dec_t   dec;

    sevenseg_stable_filter #(
        .STABLE_CYCLES(STABLE_CYCLES)
    ) u_filter (
        .clk           (clk),
        .rst_n         (rst_n),
        .run           ((state != IDLE) && enable),
        .pattern_in    (ledsegments),
        .stable_pattern(stable_pattern),
        .stable        (stable)
    );

    assign dec = seg_decode(stable_pattern);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = TRACK;
            TRACK:   if (stable && (stable_pattern != committed)) state_nxt = COMMIT;
            COMMIT:  state_nxt = TRACK;
            default: state_nxt = IDLE;
        endcase
        if (!enable) state_nxt = IDLE;
    end

    assign commit_go  = (state == TRACK) && (state_nxt == COMMIT);
    assign illegal_go = commit_go && !dec.legal && (stable_pattern != SEG_BLANK);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            committed    <= SEG_BLANK;
            digit        <= 7'd0;
            digit_valid  <= 1'b0;
            digit_strobe <= 1'b0;
            blank        <= 1'b1;
            seg_error    <= 1'b0;
            history      <= '0;
            digit_count  <= 8'd0;
        end else begin
            digit_strobe <= 1'b0;
            if (!enable) begin
                committed   <= SEG_BLANK;
                blank       <= 1'b1;
                digit_valid <= 1'b0;
            end else if (commit_go) begin
                committed <= stable_pattern;
                if (dec.legal) begin
                    digit        <= {3'b000, dec.value};
                    digit_valid  <= 1'b1;
                    blank        <= 1'b0;
                    digit_strobe <= 1'b1;
                    history      <= (history << 4) | HW'(dec.value);
                    if (digit_count != 8'hFF) digit_count <= digit_count + 8'd1;
                end else if (stable_pattern == SEG_BLANK) begin
                    blank       <= 1'b1;
                    digit_valid <= 1'b0;
                end else begin
                    blank       <= 1'b0;
                    digit_valid <= 1'b0;
                end
            end
            // a same-cycle illegal commit beats err_clear
            if (illegal_go)     seg_error <= 1'b1;
            else if (err_clear) seg_error <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sevenseg_decoder.sv
// Self-checking bench for sevenseg_decoder: a sample-history model checked
// every cycle, plus hand-computed literal checks at key points.
module tb_sevenseg_decoder;

    localparam int SC = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  ledsegments = 7'h7F;
    logic        enable = 1'b1;
    logic        err_clear = 1'b0;
    logic [6:0]  digit;
    logic        digit_valid, digit_strobe, blank, seg_error;
    logic [15:0] history;
    logic [7:0]  digit_count;

    int total = 0;
    int bad = 0;
    int seen_strobes = 0;
    bit chk_on = 1'b0;

    sevenseg_decoder #(.STABLE_CYCLES(SC), .HIST_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .ledsegments(ledsegments), .enable(enable),
        .err_clear(err_clear), .digit(digit), .digit_valid(digit_valid),
        .digit_strobe(digit_strobe), .blank(blank), .seg_error(seg_error),
        .history(history), .digit_count(digit_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    logic [6:0] pat_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                  7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    // digit value, -2 for blank, -1 for illegal
    function automatic int m_decode(input logic [6:0] p);
        if (p == 7'h7F) return -2;
        for (int i = 0; i < 10; i++) if (pat_tab[i] == p) return i;
        return -1;
    endfunction

    logic [6:0]  m_q[$];
    bit          m_prev_en = 0, m_after_commit = 0;
    logic [6:0]  m_committed = 7'h7F;
    logic [6:0]  m_digit = 0;
    logic        m_valid = 0, m_strobe = 0, m_blank = 1, m_err = 0;
    logic [15:0] m_hist = 0;
    logic [7:0]  m_count = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            m_prev_en = 0; m_after_commit = 0; m_committed = 7'h7F;
            m_digit = 0; m_valid = 0; m_strobe = 0; m_blank = 1; m_err = 0;
            m_hist = 0; m_count = 0;
        end else begin
            bit set_err, was_commit, stab_ok;
            int v;
            set_err = 0;
            m_strobe = 0;
            was_commit = m_after_commit;
            m_after_commit = 0;
            if (!enable) begin
                m_q.delete();
                m_committed = 7'h7F; m_blank = 1; m_valid = 0;
            end else if (m_prev_en) begin
                stab_ok = 0;
                if (m_q.size() >= SC) begin
                    stab_ok = 1;
                    for (int i = 1; i <= SC; i++)
                        if (m_q[m_q.size()-i] != m_q[m_q.size()-1]) stab_ok = 0;
                end
                if (stab_ok && !was_commit && m_q[m_q.size()-1] != m_committed) begin
                    m_committed = m_q[m_q.size()-1];
                    m_after_commit = 1;
                    v = m_decode(m_committed);
                    if (v >= 0) begin
                        m_digit = 7'(v); m_valid = 1; m_blank = 0; m_strobe = 1;
                        m_hist = {m_hist[11:0], 4'(v)};
                        if (m_count != 8'hFF) m_count = m_count + 8'd1;
                    end else if (v == -2) begin
                        m_blank = 1; m_valid = 0;
                    end else begin
                        m_blank = 0; m_valid = 0; set_err = 1;
                    end
                end
                m_q.push_back(ledsegments);
                if (m_q.size() > 20) void'(m_q.pop_front());
            end
            if (set_err) m_err = 1;
            else if (err_clear) m_err = 0;
            m_prev_en = enable;
        end
    end

    always @(negedge clk) begin
        if (digit_strobe) seen_strobes++;
        if (chk_on) begin
            chk("digit", 32'(digit), 32'(m_digit));
            chk("digit_valid", 32'(digit_valid), 32'(m_valid));
            chk("digit_strobe", 32'(digit_strobe), 32'(m_strobe));
            chk("blank", 32'(blank), 32'(m_blank));
            chk("seg_error", 32'(seg_error), 32'(m_err));
            chk("history", 32'(history), 32'(m_hist));
            chk("digit_count", 32'(digit_count), 32'(m_count));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic hold(input logic [6:0] p, input int n);
        ledsegments = p;
        step(n);
    endtask

    task automatic pulse_reset();
        ledsegments = 7'h7F;
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(2);
    endtask

    initial begin
        int s0;
        // 1: reset and idle blank
        step(2);
        chk_on = 1'b1;
        step(1);
        rst_n = 1'b1;
        chk("rst_blank", 32'(blank), 32'd1);
        chk("rst_history", 32'(history), 32'd0);
        chk("rst_count", 32'(digit_count), 32'd0);
        s0 = seen_strobes;
        step(20);
        chk("t1_no_strobe", 32'(seen_strobes - s0), 32'd0);

        // 2: digit 2 timing
        ledsegments = 7'h24;
        step(4);
        chk("t2_strobe_E0+3", 32'(digit_strobe), 32'd0);
        step(1);
        chk("t2_strobe_E0+4", 32'(digit_strobe), 32'd1);
        step(1);
        chk("t2_strobe_E0+5", 32'(digit_strobe), 32'd0);
        chk("t2_digit", 32'(digit), 32'd2);
        chk("t2_hist", 32'(history[3:0]), 32'd2);
        chk("t2_count", 32'(digit_count), 32'd1);
        s0 = seen_strobes;
        step(20);
        chk("t2_no_restrobe", 32'(seen_strobes - s0), 32'd0);

        // 3: glitch filtering
        s0 = seen_strobes;
        hold(7'h30, 3);
        hold(7'h7F, 10);
        chk("t3_no_strobe_a", 32'(seen_strobes - s0), 32'd0);
        chk("t3_count_a", 32'(digit_count), 32'd1);
        chk("t3_blank", 32'(blank), 32'd1);
        hold(7'h24, 10);
        chk("t3_count_b", 32'(digit_count), 32'd2);
        s0 = seen_strobes;
        hold(7'h30, 1);
        hold(7'h24, 10);
        chk("t3_no_strobe_b", 32'(seen_strobes - s0), 32'd0);
        chk("t3_count_c", 32'(digit_count), 32'd2);

        // 4: 1, blank, 1, 9 from reset
        pulse_reset();
        s0 = seen_strobes;
        hold(7'h79, 10);
        hold(7'h7F, 10);
        hold(7'h79, 10);
        hold(7'h10, 10);
        chk("t4_strobes", 32'(seen_strobes - s0), 32'd3);
        chk("t4_history", 32'(history), 32'h0119);
        chk("t4_count", 32'(digit_count), 32'd3);
        chk("t4_blank", 32'(blank), 32'd0);
        chk("t4_digit", 32'(digit), 32'd9);

        // 5: illegal patterns and error clear
        s0 = seen_strobes;
        hold(7'h55, 10);
        chk("t5_err", 32'(seg_error), 32'd1);
        chk("t5_valid", 32'(digit_valid), 32'd0);
        chk("t5_no_strobe", 32'(seen_strobes - s0), 32'd0);
        ledsegments = 7'h2A;
        step(4);
        err_clear = 1'b1;
        step(1);
        err_clear = 1'b0;
        chk("t5_set_wins", 32'(seg_error), 32'd1);
        chk("t5_blank", 32'(blank), 32'd0);
        step(3);
        err_clear = 1'b1;
        step(1);
        err_clear = 1'b0;
        chk("t5_cleared", 32'(seg_error), 32'd0);

        // 6a: reset mid-filter
        hold(7'h12, 10);
        s0 = seen_strobes;
        ledsegments = 7'h79;
        step(2);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_count", 32'(digit_count), 32'd0);
        chk("t6_rst_hist", 32'(history), 32'd0);
        chk("t6_rst_blank", 32'(blank), 32'd1);
        ledsegments = 7'h7F;
        step(1);
        rst_n = 1'b1;
        step(12);
        chk("t6_rst_no_strobe", 32'(seen_strobes - s0), 32'd0);

        // 6b: disable mid-filter
        hold(7'h12, 10);
        chk("t6_pre_hist", 32'(history), 32'h0005);
        s0 = seen_strobes;
        ledsegments = 7'h79;
        step(2);
        enable = 1'b0;
        step(10);
        chk("t6_en_no_strobe", 32'(seen_strobes - s0), 32'd0);
        chk("t6_en_hist", 32'(history), 32'h0005);
        chk("t6_en_count", 32'(digit_count), 32'd1);
        chk("t6_en_blank", 32'(blank), 32'd1);
        chk("t6_en_valid", 32'(digit_valid), 32'd0);
        enable = 1'b1;
        step(10);
        chk("t6_reenable_hist", 32'(history), 32'h0051);

        chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
